// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler: scatter/chase phase sequencer with frightened override and reverse strobe
module ghost_mode_scheduler #(
  parameter int TICK_DIV   = 2_500_000,
  parameter int SCATTER1   = 70,
  parameter int CHASE1     = 200,
  parameter int SCATTER2   = 70,
  parameter int CHASE2     = 200,
  parameter int SCATTER3   = 50,
  parameter int CHASE3     = 200,
  parameter int SCATTER4   = 50,
  parameter int FRIGHT_LEN = 60,
  parameter int FLASH_LEN  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       powerPellet,
  output logic       isScatter,
  output logic       isChase,
  output logic       isFrightened,
  output logic       frightFlash,
  output logic       reversePulse,
  output logic [2:0] phase
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] prescaler;
  logic [11:0] phase_timer, phase_timer_n, fright_timer, fright_timer_n;
  logic [2:0] phase_n;
  logic tick, pellet, run_phase, advance, fright_end, fright_n, reverse_n;
  function automatic logic [11:0] phase_len(input logic [2:0] p);
    return p == 3'd0 ? 12'(SCATTER1) : p == 3'd1 ? 12'(CHASE1) :
           p == 3'd2 ? 12'(SCATTER2) : p == 3'd3 ? 12'(CHASE2) :
           p == 3'd4 ? 12'(SCATTER3) : p == 3'd5 ? 12'(CHASE3) :
           p == 3'd6 ? 12'(SCATTER4) : 12'd0;
  endfunction
  always_comb begin
    tick = !pause && prescaler == PW'(TICK_DIV - 1);
    pellet = powerPellet && !pause && (FRIGHT_LEN != 0);
    // a fright starting this cycle freezes the schedule even on an expiring tick
    run_phase = tick && !isFrightened && !pellet && phase != 3'd7;
    advance = run_phase && phase_timer == 12'd1;
    phase_n = advance ? phase + 3'd1 : phase;
    phase_timer_n = advance ? phase_len(phase + 3'd1) : run_phase ? phase_timer - 12'd1 : phase_timer;
    fright_end = tick && isFrightened && fright_timer == 12'd1;
    fright_n = pellet || (isFrightened && !fright_end);
    fright_timer_n = pellet ? 12'(FRIGHT_LEN) : fright_end ? 12'd0 :
                     (tick && isFrightened) ? fright_timer - 12'd1 : fright_timer;
    // suppression keeps the strobe from ever spanning two consecutive cycles
    reverse_n = (pellet || advance) && !reversePulse;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      phase <= 3'd0;
      phase_timer <= 12'(SCATTER1);
      fright_timer <= 12'd0;
      isFrightened <= 1'b0;
      frightFlash <= 1'b0;
      reversePulse <= 1'b0;
    end else begin
      if (!pause) prescaler <= tick ? '0 : prescaler + 1'b1;
      phase <= phase_n;
      phase_timer <= phase_timer_n;
      fright_timer <= fright_timer_n;
      isFrightened <= fright_n;
      frightFlash <= fright_n && fright_timer_n <= 12'(FLASH_LEN);
      reversePulse <= reverse_n;
    end
  end
  assign isScatter = !isFrightened && !phase[0];
  assign isChase = !isFrightened && phase[0];
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb_ghost_mode_scheduler: directed scenarios plus randomized run against a tick-level reference model
module tb_ghost_mode_scheduler;
  localparam int TD = 4;
  localparam int FL = 60;
  localparam int FLASH = 20;
  logic clk = 1'b0, reset = 1'b1, pause = 1'b0, power_pellet = 1'b0;
  logic is_scatter, is_chase, is_frightened, fright_flash, reverse_pulse;
  logic [2:0] phase;
  int checks = 0, errors = 0, edges = 0;
  int lens[8] = '{70, 200, 70, 200, 50, 200, 50, 0};
  int m_pre, m_phase, m_pt, m_ft;
  bit m_fr, m_rev, m_flash;

  ghost_mode_scheduler #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .pause(pause), .powerPellet(power_pellet),
    .isScatter(is_scatter), .isChase(is_chase), .isFrightened(is_frightened),
    .frightFlash(fright_flash), .reversePulse(reverse_pulse), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pre = 0; m_phase = 0; m_pt = lens[0]; m_ft = 0; m_fr = 0; m_rev = 0; m_flash = 0;
  endtask

  // one clock of the game rules: ticks every TD unpaused cycles, pellets restart fright
  task automatic model_step(input bit p, input bit pp);
    bit tk, pel, adv, was_fr;
    tk = !p && m_pre == TD - 1;
    if (!p) m_pre = tk ? 0 : m_pre + 1;
    pel = pp && !p;
    was_fr = m_fr;
    adv = 0;
    if (tk && !was_fr && !pel && m_phase < 7) begin
      m_pt--;
      if (m_pt == 0) begin m_phase++; m_pt = lens[m_phase]; adv = 1; end
    end
    if (pel) begin m_fr = 1; m_ft = FL; end
    else if (tk && was_fr) begin m_ft--; if (m_ft == 0) m_fr = 0; end
    m_rev = (pel || adv) && !m_rev;
    m_flash = m_fr && m_ft <= FLASH;
  endtask

  task automatic step(input bit p, input bit pp);
    pause = p; power_pellet = pp;
    @(posedge clk);
    model_step(p, pp);
    if (!p) edges++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1; pause = 0; power_pellet = 0;
    @(posedge clk);
    model_reset();
    edges = 0;
    #1;
    reset = 0;
  endtask

  function automatic bit is_tick();
    return edges % TD == 0;
  endfunction

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (is_scatter !== 1) begin errors++; $display("FAIL reset_scatter: got %b expected 1", is_scatter); end
    if (is_chase !== 0) begin errors++; $display("FAIL reset_chase: got %b expected 0", is_chase); end
    if (is_frightened !== 0) begin errors++; $display("FAIL reset_fright: got %b expected 0", is_frightened); end
    if (fright_flash !== 0) begin errors++; $display("FAIL reset_flash: got %b expected 0", fright_flash); end
    if (reverse_pulse !== 0) begin errors++; $display("FAIL reset_reverse: got %b expected 0", reverse_pulse); end
    if (phase !== 0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
  endtask

  task automatic test_first_phase();
    int bad = 0;
    do_reset();
    for (int i = 1; i < 280; i++) begin
      step(0, 0);
      if (is_scatter !== 1 || phase !== 0 || reverse_pulse !== 0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL scatter1_hold: got %0d bad cycles expected 0", bad); end
    step(0, 0);
    checks++;
    if ({phase, is_chase, reverse_pulse} !== {3'd1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL phase1_entry: got phase=%0d chase=%b rev=%b expected 1 1 1", phase, is_chase, reverse_pulse);
    end
    step(0, 0);
    checks++;
    if (reverse_pulse !== 0) begin errors++; $display("FAIL phase1_rev_width: got %b expected 0", reverse_pulse); end
    while (edges < 1079) step(0, 0);
    checks++;
    if (phase !== 1) begin errors++; $display("FAIL phase1_end: got %0d expected 1", phase); end
    step(0, 0);
    checks++;
    if (phase !== 2) begin errors++; $display("FAIL phase2_entry: got %0d expected 2", phase); end
  endtask

  task automatic test_free_run();
    int pulses = 0, last = 0, order_bad = 0, g = 0, bad = 0;
    do_reset();
    while (phase !== 7 && g < 5000) begin
      step(0, 0); g++;
      if (reverse_pulse === 1) pulses++;
      if (int'(phase) != last) begin
        if (int'(phase) != last + 1) order_bad++;
        last = int'(phase);
      end
    end
    checks += 3;
    if (phase !== 7) begin errors++; $display("FAIL free_run_reach7: got %0d expected 7", phase); end
    if (order_bad !== 0) begin errors++; $display("FAIL free_run_order: got %0d skips expected 0", order_bad); end
    if (g !== 3360) begin errors++; $display("FAIL free_run_cycles: got %0d expected 3360", g); end
    repeat (500) begin
      step(0, 0);
      if (reverse_pulse === 1) pulses++;
      if (phase !== 7 || is_chase !== 1) bad++;
    end
    checks += 2;
    if (pulses !== 7) begin errors++; $display("FAIL free_run_pulses: got %0d expected 7", pulses); end
    if (bad !== 0) begin errors++; $display("FAIL phase7_hold: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_fright();
    int ticks = 0, flash_tick = -1, rev_extra = 0, g = 0;
    do_reset();
    repeat (280) step(0, 0);
    while (ticks < 100) begin step(0, 0); if (is_tick()) ticks++; end
    step(0, 1);
    checks++;
    if ({is_frightened, is_chase, reverse_pulse} !== 3'b101) begin
      errors++; $display("FAIL fright_start: got fr=%b ch=%b rev=%b expected 1 0 1", is_frightened, is_chase, reverse_pulse);
    end
    step(0, 0);
    checks++;
    if (reverse_pulse !== 0) begin errors++; $display("FAIL fright_rev_width: got %b expected 0", reverse_pulse); end
    ticks = 0;
    while (is_frightened === 1 && g < 1000) begin
      step(0, 0); g++;
      if (is_tick()) ticks++;
      if (fright_flash === 1 && flash_tick < 0) flash_tick = ticks;
      if (reverse_pulse === 1) rev_extra++;
    end
    checks += 4;
    if (flash_tick !== 40) begin errors++; $display("FAIL flash_rise: got tick %0d expected 40", flash_tick); end
    if (ticks !== 60) begin errors++; $display("FAIL fright_len: got %0d ticks expected 60", ticks); end
    if (rev_extra !== 0) begin errors++; $display("FAIL fright_end_rev: got %0d pulses expected 0", rev_extra); end
    if ({is_chase, phase} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL chase_resume: got ch=%b phase=%0d expected 1 1", is_chase, phase);
    end
    ticks = 0; g = 0;
    while (phase === 1 && g < 1000) begin step(0, 0); g++; if (is_tick()) ticks++; end
    checks++;
    if (ticks !== 100) begin errors++; $display("FAIL chase_remaining: got %0d ticks expected 100", ticks); end
  endtask

  task automatic test_refright();
    int ticks = 0, g = 0;
    do_reset();
    repeat (280) step(0, 0);
    step(0, 1);
    while (ticks < 30) begin step(0, 0); if (is_tick()) ticks++; end
    step(0, 1);
    checks++;
    if ({is_frightened, reverse_pulse, fright_flash} !== 3'b110) begin
      errors++; $display("FAIL refright: got fr=%b rev=%b fl=%b expected 1 1 0", is_frightened, reverse_pulse, fright_flash);
    end
    while (is_frightened === 1 && g < 1000) begin step(0, 0); g++; if (is_tick()) ticks++; end
    checks++;
    if (ticks !== 90) begin errors++; $display("FAIL refright_total: got %0d ticks expected 90", ticks); end
  endtask

  task automatic test_pause();
    logic [7:0] snap;
    int bad = 0, g = 0;
    do_reset();
    repeat (100) step(0, 0);
    snap = {is_scatter, is_chase, is_frightened, fright_flash, reverse_pulse, phase};
    for (int i = 0; i < 1000; i++) begin
      step(1, i == 500);
      if ({is_scatter, is_chase, is_frightened, fright_flash, reverse_pulse, phase} !== snap) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL pause_freeze: got %0d changed cycles expected 0", bad); end
    while (phase === 0 && g < 1000) begin step(0, 0); g++; end
    checks += 2;
    if (edges !== 280) begin errors++; $display("FAIL pause_resume: got edge %0d expected 280", edges); end
    if (is_frightened !== 0) begin errors++; $display("FAIL pause_pellet: got %b expected 0", is_frightened); end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    do_reset();
    while (phase !== 5 && g < 4000) begin step(0, 0); g++; end
    repeat (10) step(0, 0);
    step(0, 1);
    repeat (180) step(0, 0);
    checks++;
    if ({phase, is_frightened, fright_flash} !== {3'd5, 1'b1, 1'b1}) begin
      errors++; $display("FAIL pre_reset_state: got phase=%0d fr=%b fl=%b expected 5 1 1", phase, is_frightened, fright_flash);
    end
    do_reset();
    checks++;
    if ({phase, is_scatter, is_frightened, fright_flash, reverse_pulse} !== {3'd0, 4'b1000}) begin
      errors++; $display("FAIL mid_reset: got phase=%0d sc=%b fr=%b fl=%b rev=%b expected 0 1 0 0 0",
                         phase, is_scatter, is_frightened, fright_flash, reverse_pulse);
    end
  endtask

  task automatic test_simultaneous();
    int ticks = 0, g = 0;
    do_reset();
    repeat (279) step(0, 0);
    step(0, 1);
    checks++;
    if ({phase, is_frightened, reverse_pulse} !== {3'd0, 2'b11}) begin
      errors++; $display("FAIL pellet_on_expiry: got phase=%0d fr=%b rev=%b expected 0 1 1", phase, is_frightened, reverse_pulse);
    end
    while (is_frightened === 1 && g < 1000) begin step(0, 0); g++; end
    ticks = 0; g = 0;
    while (phase === 0 && g < 100) begin step(0, 0); g++; if (is_tick()) ticks++; end
    checks++;
    if ({ticks, reverse_pulse} !== {32'd1, 1'b1}) begin
      errors++; $display("FAIL resume_last_tick: got ticks=%0d rev=%b expected 1 1", ticks, reverse_pulse);
    end
    step(0, 0);
    step(0, 1);
    ticks = 0;
    while (ticks < 59) begin step(0, 0); if (is_tick()) ticks++; end
    while ((edges + 1) % TD != 0) step(0, 0);
    step(0, 1);
    checks++;
    if ({is_frightened, reverse_pulse} !== 2'b11) begin
      errors++; $display("FAIL restart_on_expiry: got fr=%b rev=%b expected 1 1", is_frightened, reverse_pulse);
    end
    ticks = 0; g = 0;
    while (is_frightened === 1 && g < 1000) begin step(0, 0); g++; if (is_tick()) ticks++; end
    checks++;
    if (ticks !== 60) begin errors++; $display("FAIL restart_len: got %0d ticks expected 60", ticks); end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    bit prev_rev = 0;
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 1999) == 0) do_reset();
      else step($urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0);
      exp = {!m_fr && m_phase % 2 == 0, !m_fr && m_phase % 2 == 1, m_fr, m_flash, m_rev, 3'(m_phase)};
      checks++;
      if ({is_scatter, is_chase, is_frightened, fright_flash, reverse_pulse, phase} !== exp) begin
        errors++; $display("FAIL random_cycle %0d: got %b expected %b", i, {is_scatter, is_chase, is_frightened, fright_flash, reverse_pulse, phase}, exp);
      end
      checks++;
      if (int'(is_scatter) + int'(is_chase) + int'(is_frightened) != 1 || (prev_rev && reverse_pulse === 1)) begin
        errors++; $display("FAIL random_invariant %0d: got sc=%b ch=%b fr=%b rev=%b prev_rev=%b", i, is_scatter, is_chase, is_frightened, reverse_pulse, prev_rev);
      end
      prev_rev = reverse_pulse;
    end
  endtask

  initial begin
    test_reset();
    test_first_phase();
    test_free_run();
    test_fright();
    test_refright();
    test_pause();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
